// File: rtl/mc_control.sv
// Multi-cycle main control FSM for the RV32I core (fetch/decode/exec/mem/wb).
// Define ILLEGAL_TRAP_EN to trap on illegal opcodes and memory timeouts.
module mc_control
`ifdef ILLEGAL_TRAP_EN
#(
    parameter int MEM_TIMEOUT = 15
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        reg_we,
    output logic [2:0]  state,
    output logic        trap
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [6:0] opc;
    logic is_alur, is_alui, is_lui, is_auipc, is_load, is_store;
    logic is_br, is_jal, is_jalr, is_fence, known;
    logic unused_bits;

    assign opc         = instr[6:0];
    assign unused_bits = ^instr[31:7];
    assign is_alur     = (opc == 7'b0110011);
    assign is_alui     = (opc == 7'b0010011);
    assign is_lui      = (opc == 7'b0110111);
    assign is_auipc    = (opc == 7'b0010111);
    assign is_load     = (opc == 7'b0000011);
    assign is_store    = (opc == 7'b0100011);
    assign is_br       = (opc == 7'b1100011);
    assign is_jal      = (opc == 7'b1101111);
    assign is_jalr     = (opc == 7'b1100111);
    assign is_fence    = (opc == 7'b0001111);
    // SYSTEM is deliberately not "known": it is unsupported here
    assign known = is_alur | is_alui | is_lui | is_auipc | is_load
                 | is_store | is_br | is_jal | is_jalr | is_fence;

`ifdef ILLEGAL_TRAP_EN
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          tmo;
    logic          waiting;

    assign waiting = (state_q == FETCH) || (state_q == MEM);
    assign tmo     = !mem_ready && (cnt == CW'(MEM_TIMEOUT - 1));

    // counts consecutive unanswered request cycles of one handshake
    always_ff @(posedge clk) begin
        if (rst || mem_ready || !waiting)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
`else
    logic tmo;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    assign state = rst ? 3'd0 : state_q;

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'b00;
        alu_a_sel    = 2'b00;
        alu_b_sel    = 1'b0;
        alu_op       = 2'b00;
        wb_sel       = 2'b00;
        reg_we       = 1'b0;
        trap         = 1'b0;
        if (rst) begin
            state_d = FETCH;
        end else begin
            unique case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    if (mem_ready)
                        state_d = DECODE;
                    else if (tmo)
                        state_d = TRAP;
                end
                DECODE: begin
                    state_d = EXEC;
`ifdef ILLEGAL_TRAP_EN
                    if (!known)
                        state_d = TRAP;
`endif
                end
                EXEC: begin
                    state_d = WB;
                    unique case (1'b1)
                        is_alur: alu_op = 2'b01;
                        is_alui: begin
                            alu_b_sel = 1'b1;
                            alu_op    = 2'b01;
                        end
                        is_lui: begin
                            alu_a_sel = 2'b10;
                            alu_b_sel = 1'b1;
                        end
                        is_auipc, is_jal: begin
                            alu_a_sel = 2'b01;
                            alu_b_sel = 1'b1;
                        end
                        is_jalr: alu_b_sel = 1'b1;
                        is_load, is_store: begin
                            alu_b_sel = 1'b1;
                            state_d   = MEM;
                        end
                        is_br: begin
                            alu_op  = 2'b10;
                            pc_we   = 1'b1;
                            pc_sel  = br_taken ? 2'b01 : 2'b00;
                            state_d = FETCH;
                        end
                        default: begin
                            // fence, and illegal ops retired as NOP
                            pc_we   = 1'b1;
                            state_d = FETCH;
                        end
                    endcase
                end
                MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = is_store;
                    if (mem_ready) begin
                        pc_we   = is_store;
                        state_d = is_store ? FETCH : WB;
                    end else if (tmo) begin
                        state_d = TRAP;
                    end
                end
                WB: begin
                    reg_we  = 1'b1;
                    pc_we   = 1'b1;
                    state_d = FETCH;
                    if (is_load)
                        wb_sel = 2'b01;
                    else if (is_jal || is_jalr)
                        wb_sel = 2'b10;
                    if (is_jal)
                        pc_sel = 2'b01;
                    else if (is_jalr)
                        pc_sel = 2'b10;
                end
                TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                    trap = 1'b1;
`endif
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Table-driven bench for mc_control: one vector per clock cycle.
// Trap-mode sequences are compiled in when ILLEGAL_TRAP_EN is defined.
module tb_mc_control;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        br_taken;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [1:0]  alu_a_sel;
    logic        alu_b_sel;
    logic [1:0]  alu_op;
    logic [1:0]  wb_sel;
    logic        reg_we;
    logic [2:0]  state;
    logic        trap;

`ifdef ILLEGAL_TRAP_EN
    mc_control #(.MEM_TIMEOUT(4)) dut (
`else
    mc_control dut (
`endif
        .clk(clk), .rst(rst), .instr(instr),
        .mem_ready(mem_ready), .br_taken(br_taken),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .alu_op(alu_op), .wb_sel(wb_sel),
        .reg_we(reg_we), .state(state), .trap(trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       trap;
        logic       req;
        logic       we;
        logic       msel;
        logic       irwe;
        logic       pcwe;
        logic [1:0] pcsel;
        logic [1:0] asel;
        logic       bsel;
        logic [1:0] op;
        logic [1:0] wb;
        logic       regwe;
    } outs_t;

    typedef struct {
        string       nm;
        logic        r;
        logic [31:0] ins;
        logic        rdy;
        logic        bt;
        outs_t       exp;
    } vec_t;

    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] ADD   = 32'h0020_81B3;
    localparam logic [31:0] LW    = 32'h0000_A103;
    localparam logic [31:0] SW    = 32'h0011_2023;
    localparam logic [31:0] BEQ   = 32'h0000_0463;
    localparam logic [31:0] JALR  = 32'h0000_80E7;
    localparam logic [31:0] JAL   = 32'h0080_00EF;
    localparam logic [31:0] LUI   = 32'h1234_50B7;
    localparam logic [31:0] AUIPC = 32'h0000_0097;
    localparam logic [31:0] FENCE = 32'h0000_000F;
    localparam logic [31:0] BAD   = 32'h0000_007F;

    vec_t tbl[$];
    int   n_chk;
    int   n_fail;

    function automatic outs_t o(int st, bit req, bit we, bit msel,
                                bit irwe, bit pcwe, int pcsel, int asel,
                                bit bsel, int op, int wb, bit regwe);
        outs_t r;
        r.st    = 3'(st);
        r.trap  = 1'b0;
        r.req   = req;
        r.we    = we;
        r.msel  = msel;
        r.irwe  = irwe;
        r.pcwe  = pcwe;
        r.pcsel = 2'(pcsel);
        r.asel  = 2'(asel);
        r.bsel  = bsel;
        r.op    = 2'(op);
        r.wb    = 2'(wb);
        r.regwe = regwe;
        return r;
    endfunction

    function automatic outs_t z();
        return o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic outs_t f(bit rdy);
        return o(0, 1, 0, 0, rdy, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic outs_t d();
        return o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic outs_t t();
        outs_t r;
        r = o(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        r.trap = 1'b1;
        return r;
    endfunction

    task automatic add(string nm, bit r, logic [31:0] ins,
                       bit rdy, bit bt, outs_t e);
        vec_t v;
        v.nm  = nm;
        v.r   = r;
        v.ins = ins;
        v.rdy = rdy;
        v.bt  = bt;
        v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic fd(string nm, logic [31:0] ins);
        add({nm, "_fetch"}, 0, ins, 1, 0, f(1));
        add({nm, "_dec"}, 0, ins, 0, 0, d());
    endtask

    task automatic step(vec_t v);
        outs_t act;
        @(negedge clk);
        rst       = v.r;
        instr     = v.ins;
        mem_ready = v.rdy;
        br_taken  = v.bt;
        #1;
        act = {state, trap, mem_req, mem_we, mem_addr_sel, ir_we,
               pc_we, pc_sel, alu_a_sel, alu_b_sel, alu_op,
               wb_sel, reg_we};
        n_chk++;
        if (act !== v.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", v.nm, act, v.exp);
        end
    endtask

    task automatic chk(string nm, bit r, logic [31:0] ins,
                       bit rdy, bit bt, outs_t e);
        vec_t v;
        v.nm  = nm;
        v.r   = r;
        v.ins = ins;
        v.rdy = rdy;
        v.bt  = bt;
        v.exp = e;
        step(v);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        instr     = '0;
        mem_ready = 1'b0;
        br_taken  = 1'b0;

        for (int i = 0; i < 3; i++)
            add($sformatf("rst%0d", i), 1, ADDI, 1, 0, z());
        add("rel_wait", 0, ADDI, 0, 0, f(0));
        add("addi_fetch", 0, ADDI, 1, 0, f(1));
        add("addi_dec", 0, ADDI, 0, 0, d());
        add("addi_ex", 0, ADDI, 0, 0, o(2,0,0,0,0,0,0,0,1,1,0,0));
        add("addi_wb", 0, ADDI, 0, 0, o(4,0,0,0,0,1,0,0,0,0,0,1));

        fd("lw", LW);
        add("lw_ex", 0, LW, 0, 0, o(2,0,0,0,0,0,0,0,1,0,0,0));
        add("lw_mw0", 0, LW, 0, 0, o(3,1,0,1,0,0,0,0,0,0,0,0));
        add("lw_mw1", 0, LW, 0, 0, o(3,1,0,1,0,0,0,0,0,0,0,0));
        add("lw_mok", 0, LW, 1, 0, o(3,1,0,1,0,0,0,0,0,0,0,0));
        add("lw_wb", 0, LW, 0, 0, o(4,0,0,0,0,1,0,0,0,0,1,1));

        fd("sw", SW);
        add("sw_ex", 0, SW, 0, 0, o(2,0,0,0,0,0,0,0,1,0,0,0));
        add("sw_mem", 0, SW, 1, 0, o(3,1,1,1,0,1,0,0,0,0,0,0));

        fd("beqt", BEQ);
        add("beqt_ex", 0, BEQ, 0, 1, o(2,0,0,0,0,1,1,0,0,2,0,0));
        fd("beqn", BEQ);
        add("beqn_ex", 0, BEQ, 0, 0, o(2,0,0,0,0,1,0,0,0,2,0,0));

        fd("jalr", JALR);
        add("jalr_ex", 0, JALR, 0, 0, o(2,0,0,0,0,0,0,0,1,0,0,0));
        add("jalr_wb", 0, JALR, 0, 0, o(4,0,0,0,0,1,2,0,0,0,2,1));
        fd("jal", JAL);
        add("jal_ex", 0, JAL, 0, 0, o(2,0,0,0,0,0,0,1,1,0,0,0));
        add("jal_wb", 0, JAL, 0, 0, o(4,0,0,0,0,1,1,0,0,0,2,1));
        fd("lui", LUI);
        add("lui_ex", 0, LUI, 0, 0, o(2,0,0,0,0,0,0,2,1,0,0,0));
        add("lui_wb", 0, LUI, 0, 0, o(4,0,0,0,0,1,0,0,0,0,0,1));
        fd("auipc", AUIPC);
        add("auipc_ex", 0, AUIPC, 0, 0, o(2,0,0,0,0,0,0,1,1,0,0,0));
        add("auipc_wb", 0, AUIPC, 0, 0, o(4,0,0,0,0,1,0,0,0,0,0,1));
        fd("add", ADD);
        add("add_ex", 0, ADD, 0, 0, o(2,0,0,0,0,0,0,0,0,1,0,0));
        add("add_wb", 0, ADD, 0, 0, o(4,0,0,0,0,1,0,0,0,0,0,1));
        fd("fence", FENCE);
        add("fence_ex", 0, FENCE, 0, 0, o(2,0,0,0,0,1,0,0,0,0,0,0));

        fd("mrst", LW);
        add("mrst_ex", 0, LW, 0, 0, o(2,0,0,0,0,0,0,0,1,0,0,0));
        add("mrst_mem", 0, LW, 0, 0, o(3,1,0,1,0,0,0,0,0,0,0,0));
        add("mrst_rst", 1, LW, 1, 0, z());
        add("mrst_rel", 0, LW, 0, 0, f(0));
        add("frst_rst", 1, ADDI, 1, 0, z());
        add("frst_rel", 0, ADDI, 0, 0, f(0));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i]);

        chk("bad_fetch", 0, BAD, 1, 0, f(1));
        chk("bad_dec", 0, BAD, 0, 0, d());
`ifdef ILLEGAL_TRAP_EN
        chk("bad_trap0", 0, BAD, 1, 0, t());
        chk("bad_trap1", 0, BAD, 1, 1, t());
        chk("bad_rst", 1, BAD, 0, 0, z());
        for (int i = 0; i < 4; i++)
            chk($sformatf("tmo_wait%0d", i), 0, ADDI, 0, 0, f(0));
        chk("tmo_trap0", 0, ADDI, 0, 0, t());
        chk("tmo_trap1", 0, ADDI, 1, 0, t());
        chk("tmo_rst", 1, ADDI, 0, 0, z());
        chk("tmo_rel", 0, ADDI, 1, 0, f(1));
`else
        chk("bad_ex", 0, BAD, 0, 0, o(2,0,0,0,0,1,0,0,0,0,0,0));
        chk("bad_back", 0, ADDI, 0, 0, f(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
